mult_session_ctrl: RTL and testbench
====================================

# mult_session_ctrl

Sequencing controller for the signed 8x8 multiply-and-display datapath. It captures operands on a start request, drives the sequential multiplier's start/done handshake, pulses the shift register's load once the product is ready, and then turns user scroll requests into bounded shift commands with a tracked window offset. It sits between the push-button edge detectors and the multiplier / BCD shift register.

## Interface
Parameters:
- OP_W, 8, operand width
- MAX_OFFSET, 2, maximum scroll offset in BCD digits (5-digit result, 3-digit window)
- TIMEOUT_CYC, 64, clk cycles allowed from mult_start rising to mult_done (only with watchdog)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start_req  in  1  single-cycle pulse from the start button detector
- clear_req  in  1  single-cycle pulse; synchronous return to IDLE
- shl_req  in  1  single-cycle scroll-left pulse
- shr_req  in  1  single-cycle scroll-right pulse
- num1_in  in  OP_W  raw operand 1
- num2_in  in  OP_W  raw operand 2
- mult_done  in  1  multiplier done level
- mult_start  out  1  multiplier start level, held for the whole multiply
- op_a  out  OP_W  latched operand 1
- op_b  out  OP_W  latched operand 2
- load  out  1  one-cycle shift-register load pulse
- shift_en  out  1  one-cycle shift pulse
- shift_dir  out  1  1 = right, 0 = left; meaningful only while shift_en = 1
- offset  out  2  current scroll offset, 0..MAX_OFFSET
- busy  out  1  high in MULT and LOAD
- result_valid  out  1  high in SHOW
- error  out  1  high in ERR (watchdog only)

## Operation
- States: IDLE, MULT, LOAD, SHOW, ERR.
- IDLE, start_req: latch op_a/op_b from num1_in/num2_in, go to MULT.
- MULT: mult_start = 1. When mult_done = 1, go to LOAD. start_req and shift requests are ignored.
- LOAD: mult_start = 0, load = 1 for exactly one cycle, offset cleared to 0, then go to SHOW.
- SHOW:
  - shl_req alone with offset < MAX_OFFSET: shift_en = 1, shift_dir = 0, offset + 1.
  - shr_req alone with offset > 0: shift_en = 1, shift_dir = 1, offset − 1.
  - A request at the bound is dropped: no shift_en, offset unchanged.
  - shl_req and shr_req in the same cycle: both dropped.
  - start_req: re-latch operands, clear result_valid, go to MULT. It has priority over shift requests in the same cycle.
- clear_req in any state: go to IDLE, deassert all outputs, offset = 0. It has priority over every other input.
- Reset values: state IDLE; op_a, op_b, offset = 0; all 1-bit outputs 0.

## Timing
- start_req sampled at edge N: op_a/op_b valid and mult_start high from N+1.
- mult_done first sampled high at edge M: mult_start low and load high during cycle M+1; result_valid high from M+2.
- Shift request sampled at edge N: shift_en high for cycle N+1 only, and offset updates at the same edge.
- All outputs are registered; there are no combinational input-to-output paths.
- rst_n asserted mid-multiply: outputs drop to reset values immediately (asynchronously); operation resumes only on a new start_req after release.

## Configuration
- MULT_WATCHDOG_EN defined:
  - A counter runs in MULT.
  - If mult_done is not seen within TIMEOUT_CYC cycles, go to ERR: mult_start = 0, error = 1.
  - ERR exits on clear_req (to IDLE) or start_req (re-latch, to MULT).
- MULT_WATCHDOG_EN undefined: no counter, ERR is unreachable, error is tied to 0, and MULT waits indefinitely.

## Structure
- Shared package mult_ctrl_pkg holds:
  - state enum type
  - OFFSET_W = 2
  - default MAX_OFFSET and TIMEOUT_CYC constants
- One sub-module, mult_watchdog_timer, instantiated only under MULT_WATCHDOG_EN. Ports: clk, rst_n, run, expired.

## Test plan
- Reset then start_req with num1_in = 8'h05, num2_in = 8'h07: op_a = 5, op_b = 7 and mult_start = 1 on the next cycle; model mult_done after 9 cycles -> load pulses for exactly one cycle, then result_valid = 1, offset = 0.
- In SHOW, three shl_req pulses -> shift_en pulses twice with shift_dir = 0, offset reaches 2 and stays there; one shr_req -> shift_en with shift_dir = 1, offset = 1.
- shl_req and shr_req in the same cycle at offset 1 -> no shift_en, offset stays 1; start_req in MULT -> ignored, operands unchanged.
- clear_req in the same cycle as mult_done in MULT -> IDLE next cycle, no load pulse, mult_start = 0.
- With MULT_WATCHDOG_EN, TIMEOUT_CYC = 16 and mult_done held low -> error = 1 and mult_start = 0 after 16 cycles; start_req -> back to MULT with error = 0.
- rst_n pulsed low mid-MULT -> every output is 0 immediately, and state is IDLE after release.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the multiply-and-display session controller.
// Contents: FSM state enum, scroll offset width, default scroll bound and
// multiplier watchdog timeout.
package mult_ctrl_pkg;

  localparam int unsigned OFFSET_W            = 2;
  localparam int unsigned DEFAULT_MAX_OFFSET  = 2;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    StIdle,
    StMult,
    StLoad,
    StShow,
    StErr
  } state_e;

endpackage

// File: rtl/mult_watchdog_timer.sv
// Cycle counter that flags a multiply that has run too long.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   run_i      high while the multiply is in progress; low clears the count
//   expired_o  high during the Timeout-th consecutive cycle of run_i
module mult_watchdog_timer #(
  parameter int unsigned Timeout = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count 0 is the first run cycle, so Timeout-1 marks the last allowed one.
  assign expired_o = run_i && (cnt_q == CntW'(Timeout - 1));

endmodule

// File: rtl/mult_session_ctrl.sv
// Session controller for the signed multiply-and-display datapath: captures
// operands, runs the multiplier start/done handshake, pulses the shift
// register load and turns scroll requests into bounded shift commands.
// Optional build macro MULT_WATCHDOG_EN adds a multiply timeout that ends in
// an error state; without it the multiply waits indefinitely.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   start_req_i, clear_req_i  single-cycle session start / clear requests
//   shl_req_i, shr_req_i      single-cycle scroll left / right requests
//   num1_i, num2_i            raw operands
//   mult_done_i               multiplier done level
//   mult_start_o              multiplier start level, held during the multiply
//   op_a_o, op_b_o            latched operands
//   load_o                    one-cycle shift register load pulse
//   shift_en_o, shift_dir_o   one-cycle shift pulse, direction (1 = right)
//   offset_o                  current scroll offset
//   busy_o, result_valid_o    multiply in progress / result on display
//   error_o                   multiply timed out
// All outputs are registered.
module mult_session_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned OP_W        = 8,
  parameter int unsigned MAX_OFFSET  = DEFAULT_MAX_OFFSET,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_req_i,
  input  logic                clear_req_i,
  input  logic                shl_req_i,
  input  logic                shr_req_i,
  input  logic [OP_W-1:0]     num1_i,
  input  logic [OP_W-1:0]     num2_i,
  input  logic                mult_done_i,
  output logic                mult_start_o,
  output logic [OP_W-1:0]     op_a_o,
  output logic [OP_W-1:0]     op_b_o,
  output logic                load_o,
  output logic                shift_en_o,
  output logic                shift_dir_o,
  output logic [OFFSET_W-1:0] offset_o,
  output logic                busy_o,
  output logic                result_valid_o,
  output logic                error_o
);

  localparam logic [OFFSET_W-1:0] MaxOff = OFFSET_W'(MAX_OFFSET);

  state_e state_q, state_d;
  logic   latch_ops;
  logic   wd_expired;

  logic                mult_start_q, mult_start_d;
  logic [OP_W-1:0]     op_a_q, op_a_d;
  logic [OP_W-1:0]     op_b_q, op_b_d;
  logic                load_q, load_d;
  logic                shift_en_q, shift_en_d;
  logic                shift_dir_q, shift_dir_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                busy_q, busy_d;
  logic                result_valid_q, result_valid_d;

`ifdef MULT_WATCHDOG_EN
  logic error_q, error_d;

  mult_watchdog_timer #(
    .Timeout (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .run_i     (state_q == StMult),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear beats everything, done beats the watchdog.
  always_comb begin
    state_d   = state_q;
    latch_ops = 1'b0;
    if (clear_req_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StShow, StErr: begin
          if (start_req_i) begin
            state_d   = StMult;
            latch_ops = 1'b1;
          end
        end
        StMult: begin
          if (mult_done_i) begin
            state_d = StLoad;
          end else if (wd_expired) begin
            state_d = StErr;
          end
        end
        StLoad:  state_d = StShow;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    mult_start_d   = (state_d == StMult);
    load_d         = (state_d == StLoad);
    busy_d         = (state_d == StMult) || (state_d == StLoad);
    result_valid_d = (state_d == StShow);
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    offset_d       = offset_q;
    shift_en_d     = 1'b0;
    shift_dir_d    = 1'b0;
`ifdef MULT_WATCHDOG_EN
    error_d        = (state_d == StErr);
`endif
    if (clear_req_i) begin
      op_a_d   = '0;
      op_b_d   = '0;
      offset_d = '0;
    end else if (latch_ops) begin
      op_a_d = num1_i;
      op_b_d = num2_i;
    end else if (state_d == StLoad) begin
      offset_d = '0;
    end else if (state_q == StShow && (shl_req_i ^ shr_req_i)) begin
      // Simultaneous left and right cancel; requests at a bound are dropped.
      if (shl_req_i && offset_q < MaxOff) begin
        shift_en_d = 1'b1;
        offset_d   = offset_q + 1'b1;
      end else if (shr_req_i && offset_q != '0) begin
        shift_en_d  = 1'b1;
        shift_dir_d = 1'b1;
        offset_d    = offset_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mult_start_q   <= 1'b0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      load_q         <= 1'b0;
      shift_en_q     <= 1'b0;
      shift_dir_q    <= 1'b0;
      offset_q       <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      mult_start_q   <= mult_start_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      load_q         <= load_d;
      shift_en_q     <= shift_en_d;
      shift_dir_q    <= shift_dir_d;
      offset_q       <= offset_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

`ifdef MULT_WATCHDOG_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end
  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign mult_start_o   = mult_start_q;
  assign op_a_o         = op_a_q;
  assign op_b_o         = op_b_q;
  assign load_o         = load_q;
  assign shift_en_o     = shift_en_q;
  assign shift_dir_o    = shift_dir_q;
  assign offset_o       = offset_q;
  assign busy_o         = busy_q;
  assign result_valid_o = result_valid_q;

endmodule

// File: tb/tb_mult_session_ctrl.sv
// Self-checking bench for mult_session_ctrl. Expected operands and scroll
// results go into scoreboard queues when stimulus is driven and are popped
// when the DUT responds.
module tb_mult_session_ctrl;

  localparam int unsigned OpW = 8;

  logic           clk;
  logic           rst_n;
  logic           start_req, clear_req, shl_req, shr_req;
  logic [OpW-1:0] num1, num2;
  logic           mult_done;
  logic           mult_start, load, shift_en, shift_dir, busy, result_valid, error;
  logic [OpW-1:0] op_a, op_b;
  logic [1:0]     offset;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic       en;
    logic       dir;
    logic [1:0] off;
  } shift_exp_t;

  shift_exp_t          shift_sb[$];
  logic [2*OpW-1:0]    ops_sb[$];
  logic [1:0]          off_m;

  mult_session_ctrl #(
    .OP_W        (OpW),
    .MAX_OFFSET  (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_req_i    (start_req),
    .clear_req_i    (clear_req),
    .shl_req_i      (shl_req),
    .shr_req_i      (shr_req),
    .num1_i         (num1),
    .num2_i         (num2),
    .mult_done_i    (mult_done),
    .mult_start_o   (mult_start),
    .op_a_o         (op_a),
    .op_b_o         (op_b),
    .load_o         (load),
    .shift_en_o     (shift_en),
    .shift_dir_o    (shift_dir),
    .offset_o       (offset),
    .busy_o         (busy),
    .result_valid_o (result_valid),
    .error_o        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {mult_start, load, shift_en, shift_dir, busy, result_valid, error,
            offset, op_a, op_b};
  endfunction

  // Pulse start_req and check the operands popped from the scoreboard.
  task automatic do_start(input logic [OpW-1:0] a, input logic [OpW-1:0] b);
    logic [2*OpW-1:0] exp_ops;
    num1 = a;
    num2 = b;
    start_req = 1'b1;
    ops_sb.push_back({a, b});
    tick();
    start_req = 1'b0;
    exp_ops = ops_sb.pop_front();
    tests_run++;
    if ({op_a, op_b} !== exp_ops || mult_start !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_latch: ops=%h ms=%b busy=%b, required ops=%h ms=1 busy=1",
               {op_a, op_b}, mult_start, busy, exp_ops);
    end
  endtask

  // Drive mult_done once and check the load pulse and the move to SHOW.
  task automatic finish_mult();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    tests_run++;
    if (load !== 1'b1 || mult_start !== 1'b0 || offset !== 2'd0 || result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_pulse: load=%b ms=%b off=%0d rv=%b, required 1 0 0 0",
               load, mult_start, offset, result_valid);
    end
    tick();
    tests_run++;
    if (load !== 1'b0 || result_valid !== 1'b1 || busy !== 1'b0 || offset !== 2'd0) begin
      tests_failed++;
      $display("FAIL show_entry: load=%b rv=%b busy=%b off=%0d, required 0 1 0 0",
               load, result_valid, busy, offset);
    end
    off_m = 2'd0;
  endtask

  task automatic do_shift(input logic l, input logic r);
    shift_exp_t e;
    shift_exp_t got;
    e.en  = 1'b0;
    e.dir = 1'b0;
    e.off = off_m;
    if (l && !r && off_m < 2'd2) begin
      e.en = 1'b1;
      e.off = off_m + 2'd1;
    end else if (r && !l && off_m > 2'd0) begin
      e.en = 1'b1;
      e.dir = 1'b1;
      e.off = off_m - 2'd1;
    end
    off_m = e.off;
    shift_sb.push_back(e);
    shl_req = l;
    shr_req = r;
    tick();
    shl_req = 1'b0;
    shr_req = 1'b0;
    got = shift_sb.pop_front();
    tests_run++;
    if (shift_en !== got.en || offset !== got.off || (got.en && shift_dir !== got.dir)) begin
      tests_failed++;
      $display("FAIL shift l=%b r=%b: en=%b dir=%b off=%0d, required en=%b dir=%b off=%0d",
               l, r, shift_en, shift_dir, offset, got.en, got.dir, got.off);
    end
    tick();
    tests_run++;
    if (shift_en !== 1'b0 || offset !== got.off) begin
      tests_failed++;
      $display("FAIL shift_one_cycle: en=%b off=%0d, required en=0 off=%0d",
               shift_en, offset, got.off);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_req = 1'b0;
    clear_req = 1'b0;
    shl_req = 1'b0;
    shr_req = 1'b0;
    mult_done = 1'b0;
    num1 = '0;
    num2 = '0;
    off_m = 2'd0;
    #2;
    tests_run++;
    if (all_outs() !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_values: outs=%h, required 0", all_outs());
    end
    #20;
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (all_outs() !== 32'd0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: outs=%h, required 0", all_outs());
    end
  endtask

  task automatic test_basic_mult();
    do_start(8'h05, 8'h07);
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    tests_run++;
    if (mult_start !== 1'b1 || load !== 1'b0 || result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mult_hold: ms=%b load=%b rv=%b, required 1 0 0",
               mult_start, load, result_valid);
    end
    finish_mult();
  endtask

  task automatic test_scroll();
    do_shift(1'b1, 1'b0);
    do_shift(1'b1, 1'b0);
    do_shift(1'b1, 1'b0);
    do_shift(1'b0, 1'b1);
    do_shift(1'b1, 1'b1);
    do_shift(1'b0, 1'b1);
    do_shift(1'b0, 1'b1);
  endtask

  task automatic test_start_in_mult();
    do_start(8'hFB, 8'h03);
    tests_run++;
    if (result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_clears_valid: rv=%b, required 0", result_valid);
    end
    num1 = 8'h11;
    num2 = 8'h22;
    start_req = 1'b1;
    shl_req = 1'b1;
    tick();
    start_req = 1'b0;
    shl_req = 1'b0;
    tests_run++;
    if (op_a !== 8'hFB || op_b !== 8'h03 || mult_start !== 1'b1 || shift_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_ignored_in_mult: ops=%h ms=%b se=%b, required fb03 1 0",
               {op_a, op_b}, mult_start, shift_en);
    end
    finish_mult();
    // Start beats a same-cycle scroll request in SHOW.
    num1 = 8'h42;
    num2 = 8'h24;
    start_req = 1'b1;
    shl_req = 1'b1;
    tick();
    start_req = 1'b0;
    shl_req = 1'b0;
    tests_run++;
    if (shift_en !== 1'b0 || mult_start !== 1'b1 || op_a !== 8'h42 || op_b !== 8'h24) begin
      tests_failed++;
      $display("FAIL start_priority: se=%b ms=%b ops=%h, required 0 1 4224",
               shift_en, mult_start, {op_a, op_b});
    end
  endtask

  task automatic test_clear_with_done();
    tick();
    tick();
    mult_done = 1'b1;
    clear_req = 1'b1;
    tick();
    mult_done = 1'b0;
    clear_req = 1'b0;
    tests_run++;
    if (all_outs() !== 32'd0) begin
      tests_failed++;
      $display("FAIL clear_over_done: outs=%h, required 0", all_outs());
    end
    tick();
    tests_run++;
    if (load !== 1'b0 || mult_start !== 1'b0 || result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_stays_idle: load=%b ms=%b rv=%b, required 0 0 0",
               load, mult_start, result_valid);
    end
  endtask

`ifdef MULT_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    n = 0;
    do_start(8'h81, 8'h7F);
    while (error !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != 16 || error !== 1'b1 || mult_start !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL watchdog: cycles=%0d err=%b ms=%b busy=%b, required 16 1 0 0",
               n, error, mult_start, busy);
    end
    do_start(8'h12, 8'h34);
    tests_run++;
    if (error !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_exit_start: err=%b, required 0", error);
    end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
  endtask
`else
  task automatic test_no_watchdog();
    do_start(8'h81, 8'h7F);
    for (int i = 0; i < 80; i++) begin
      tick();
    end
    tests_run++;
    if (mult_start !== 1'b1 || error !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mult_waits: ms=%b err=%b busy=%b, required 1 0 1",
               mult_start, error, busy);
    end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_mult();
    do_start(8'h33, 8'h44);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (all_outs() !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_reset: outs=%h, required 0", all_outs());
    end
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if (all_outs() !== 32'd0) begin
      tests_failed++;
      $display("FAIL idle_after_release: outs=%h, required 0", all_outs());
    end
    do_start(8'h80, 8'hFF);
    finish_mult();
  endtask

  initial begin
    test_reset();
    test_basic_mult();
    test_scroll();
    test_start_in_mult();
    test_clear_with_done();
`ifdef MULT_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    test_reset_mid_mult();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
